// File: rtl/raster_pkg.sv
// Shared raster constants and fill-sequencer types.
// Imported by the fill controller, its scan counter and the rasterizer.
package raster_pkg;

  localparam int H_RES   = 320;
  localparam int V_RES   = 240;
  localparam int COORD_W = 9;
  localparam int COLOR_W = 8;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COLOR_W-1:0] color_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    RUN,
    DONE
  } fill_state_t;

  localparam coord_t X_LAST = coord_t'(H_RES - 1);
  localparam coord_t Y_LAST = coord_t'(V_RES - 1);
  localparam coord_t X_LIM  = coord_t'(H_RES);
  localparam coord_t Y_LIM  = coord_t'(V_RES);

endpackage

// File: rtl/rect_fill_ctrl_if.sv
// Command and pixel-stream bundle of the rectangle fill sequencer.
// slave is the sequencer side, master the command/pixel-sink side.
interface rect_fill_ctrl_if;
  import raster_pkg::*;

  logic   cmd_valid;
  logic   cmd_ready;
  coord_t cmd_x0;
  coord_t cmd_y0;
  coord_t cmd_x1;
  coord_t cmd_y1;
  color_t cmd_color;
  logic   abort;
  coord_t pixel_x;
  coord_t pixel_y;
  color_t pixel_color;
  logic   pixel_valid;
  logic   pixel_ready;
  logic   busy;
  logic   done;

  modport slave (
    input  cmd_valid,
    input  cmd_x0,
    input  cmd_y0,
    input  cmd_x1,
    input  cmd_y1,
    input  cmd_color,
    input  abort,
    input  pixel_ready,
    output cmd_ready,
    output pixel_x,
    output pixel_y,
    output pixel_color,
    output pixel_valid,
    output busy,
    output done
  );

  modport master (
    output cmd_valid,
    output cmd_x0,
    output cmd_y0,
    output cmd_x1,
    output cmd_y1,
    output cmd_color,
    output abort,
    output pixel_ready,
    input  cmd_ready,
    input  pixel_x,
    input  pixel_y,
    input  pixel_color,
    input  pixel_valid,
    input  busy,
    input  done
  );

endinterface

// File: rtl/raster_scan_counter.sv
// Loadable 2-D raster counter: walks x then y inside a box.
// last flags the bottom-right corner of the loaded box.
module raster_scan_counter
  import raster_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   load,
  input  logic   adv,
  input  coord_t xmin,
  input  coord_t ymin,
  input  coord_t xmax,
  input  coord_t ymax,
  output coord_t cur_x,
  output coord_t cur_y,
  output logic   last
);

  coord_t xmin_q;
  coord_t xmax_q;
  coord_t ymax_q;

  // Box bounds and raster position; wrap x to xmin at end of row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xmin_q <= '0;
      xmax_q <= '0;
      ymax_q <= '0;
      cur_x  <= '0;
      cur_y  <= '0;
    end else if (load) begin
      xmin_q <= xmin;
      xmax_q <= xmax;
      ymax_q <= ymax;
      cur_x  <= xmin;
      cur_y  <= ymin;
    end else if (adv) begin
      if (cur_x < xmax_q) begin
        cur_x <= cur_x + coord_t'(1);
      end else begin
        cur_x <= xmin_q;
        cur_y <= cur_y + coord_t'(1);
      end
    end
  end

  assign last = (cur_x == xmax_q) && (cur_y == ymax_q);

endmodule

// File: rtl/rect_fill_ctrl.sv
// Rectangle fill sequencer: normalise, clip, then stream pixels.
// One pixel per cycle under valid/ready; abort drops the rest.
module rect_fill_ctrl
  import raster_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  rect_fill_ctrl_if.slave bus
);

  fill_state_t state_q;
  fill_state_t state_d;

  coord_t x0_q;
  coord_t y0_q;
  coord_t x1_q;
  coord_t y1_q;
  color_t color_q;

  logic   pv_q;
  logic   done_q;

  logic   latch;
  logic   load;
  logic   adv;
  logic   last;
  logic   xfer;
  logic   empty;

  coord_t xmin;
  coord_t ymin;
  coord_t xmax_raw;
  coord_t ymax_raw;
  coord_t xmax;
  coord_t ymax;
  coord_t cur_x;
  coord_t cur_y;

  assign xmin     = (x0_q < x1_q) ? x0_q : x1_q;
  assign xmax_raw = (x0_q < x1_q) ? x1_q : x0_q;
  assign ymin     = (y0_q < y1_q) ? y0_q : y1_q;
  assign ymax_raw = (y0_q < y1_q) ? y1_q : y0_q;
  assign xmax     = (xmax_raw > X_LAST) ? X_LAST : xmax_raw;
  assign ymax     = (ymax_raw > Y_LAST) ? Y_LAST : ymax_raw;
  assign empty    = (xmin >= X_LIM) || (ymin >= Y_LIM);

  assign xfer = pv_q && bus.pixel_ready;

  raster_scan_counter u_scan (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .adv     (adv),
    .xmin    (xmin),
    .ymin    (ymin),
    .xmax    (xmax),
    .ymax    (ymax),
    .cur_x   (cur_x),
    .cur_y   (cur_y),
    .last    (last)
  );

  // Next state and per-cycle strobes for latch/load/advance.
  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    load    = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          latch   = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (bus.abort || empty) begin
          state_d = DONE;
        end else begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        adv = xfer && !last;
        if ((xfer && last) || bus.abort) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register plus registered valid/done derived from next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pv_q    <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  // Capture the command corners and colour on accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
    end else if (latch) begin
      x0_q    <= bus.cmd_x0;
      y0_q    <= bus.cmd_y0;
      x1_q    <= bus.cmd_x1;
      y1_q    <= bus.cmd_y1;
      color_q <= bus.cmd_color;
    end
  end

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.busy        = (state_q == SETUP) || (state_q == RUN);
  assign bus.pixel_x     = cur_x;
  assign bus.pixel_y     = cur_y;
  assign bus.pixel_color = color_q;
  assign bus.pixel_valid = pv_q;
  assign bus.done        = done_q;

endmodule
